// File: rtl/osd_trigger_pulser.sv
// Multi-channel OSD trigger pulser with a global reset stretcher.
// Each trigger channel emits one fixed-width pulse per synchronised rising edge.
module osd_trigger_pulser #(
    parameter int unsigned       NUM_CH      = 4,
    parameter int unsigned       CNT_W       = 17,
    parameter int unsigned       PULSE_LEN   = 50000,
    parameter int unsigned       RST_LEN     = 65535,
    parameter logic [NUM_CH-1:0] RETRIG_MASK = '0,
    parameter int unsigned       RST_CH      = NUM_CH
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic [NUM_CH-1:0]     trig_in,
    input  logic                  ext_rst_in,
    output logic [NUM_CH-1:0]     pulse_out,
    output logic [8*NUM_CH-1:0]   edge_cnt,
    output logic                  sys_rst,
    output logic                  sys_rst_n
);

    if (NUM_CH == 0 || NUM_CH > 16) begin : g_bad_num_ch
        $error("osd_trigger_pulser: NUM_CH must be 1..16");
    end
    if (PULSE_LEN == 0 || 64'(PULSE_LEN) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_pulse_len
        $error("osd_trigger_pulser: PULSE_LEN must be 1..2^CNT_W-1");
    end
    if (RST_LEN == 0 || 64'(RST_LEN) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_rst_len
        $error("osd_trigger_pulser: RST_LEN must be 1..2^CNT_W-1");
    end

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] RST_LOAD   = CNT_W'(RST_LEN - 1);

    typedef enum logic {
        CH_IDLE,
        CH_ACTIVE
    } ch_state_t;

    typedef enum logic [1:0] {
        RS_HOLD,
        RS_COUNT,
        RS_RUN
    } rs_state_t;

    // Sync chain presets to ones so a level already high at release is not an edge.
    logic [NUM_CH-1:0] s1, s2, s3;
    logic [NUM_CH-1:0] trig_edge;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            s1 <= '1;
            s2 <= '1;
            s3 <= '1;
        end else begin
            s1 <= trig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign trig_edge = s2 & ~s3;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam bit RETRIG = RETRIG_MASK[i];

        ch_state_t        state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [7:0]       ecnt_q, ecnt_d;
        logic             pulse_q;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            ecnt_d  = ecnt_q;
            case (state_q)
                CH_IDLE: begin
                    cnt_d = '0;
                    if (trig_edge[i]) begin
                        state_d = CH_ACTIVE;
                        cnt_d   = PULSE_LOAD;
                        ecnt_d  = ecnt_q + 8'd1;
                    end
                end
                CH_ACTIVE: begin
                    if (RETRIG && trig_edge[i]) begin
                        cnt_d  = PULSE_LOAD;
                        ecnt_d = ecnt_q + 8'd1;
                    end else if (cnt_q == '0) begin
                        state_d = CH_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = CH_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Output is a registered copy of the state, giving the edge-to-pulse latency of three clocks.
        always_ff @(posedge clk_sys) begin
            if (reset) begin
                state_q <= CH_IDLE;
                cnt_q   <= '0;
                ecnt_q  <= '0;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                ecnt_q  <= ecnt_d;
                pulse_q <= (state_q == CH_ACTIVE);
            end
        end

        assign pulse_out[i]         = pulse_q;
        assign edge_cnt[8*i +: 8]   = ecnt_q;
    end

    logic ers1, ers2;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ers1 <= 1'b0;
            ers2 <= 1'b0;
        end else begin
            ers1 <= ext_rst_in;
            ers2 <= ers1;
        end
    end

    logic rst_fire;

    if (RST_CH < NUM_CH) begin : g_rst_ch
        logic pulse_prev;

        always_ff @(posedge clk_sys) begin
            if (reset) begin
                pulse_prev <= 1'b0;
            end else begin
                pulse_prev <= pulse_out[RST_CH];
            end
        end

        assign rst_fire = pulse_out[RST_CH] & ~pulse_prev;
    end else begin : g_no_rst_ch
        assign rst_fire = 1'b0;
    end

    rs_state_t        rs_q, rs_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic             rst_cause;

    assign rst_cause = reset | ers2 | rst_fire;

    always_comb begin
        rs_d   = rs_q;
        rcnt_d = rcnt_q;
        if (rst_cause) begin
            rs_d   = RS_HOLD;
            rcnt_d = RST_LOAD;
        end else begin
            case (rs_q)
                RS_HOLD: begin
                    rs_d   = RS_COUNT;
                    rcnt_d = RST_LOAD;
                end
                RS_COUNT: begin
                    if (rcnt_q == '0) begin
                        rs_d = RS_RUN;
                    end else begin
                        rcnt_d = rcnt_q - CNT_W'(1);
                    end
                end
                RS_RUN: begin
                    rcnt_d = '0;
                end
                default: begin
                    rs_d   = RS_HOLD;
                    rcnt_d = RST_LOAD;
                end
            endcase
        end
    end

    // Both reset outputs are registered from the next state so they stay exact complements.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rs_q      <= RS_HOLD;
            rcnt_q    <= CNT_W'(RST_LEN);
            sys_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
        end else begin
            rs_q      <= rs_d;
            rcnt_q    <= rcnt_d;
            sys_rst   <= (rs_d != RS_RUN);
            sys_rst_n <= (rs_d == RS_RUN);
        end
    end

endmodule

// File: tb/tb_osd_trigger_pulser.sv
// Scoreboard bench for osd_trigger_pulser: expected pulse and reset windows are queued
// by the stimulus process and consumed by a monitor when each window closes.
module tb_osd_trigger_pulser;

    localparam int NCH = 4;

    logic               clk_sys = 1'b0;
    logic               reset;
    logic [NCH-1:0]     trig_in;
    logic               ext_rst_in;
    logic [NCH-1:0]     pulse_out;
    logic [8*NCH-1:0]   edge_cnt;
    logic               sys_rst;
    logic               sys_rst_n;

    osd_trigger_pulser #(
        .NUM_CH      (NCH),
        .CNT_W       (17),
        .PULSE_LEN   (5),
        .RST_LEN     (8),
        .RETRIG_MASK (4'b0010),
        .RST_CH      (3)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .trig_in    (trig_in),
        .ext_rst_in (ext_rst_in),
        .pulse_out  (pulse_out),
        .edge_cnt   (edge_cnt),
        .sys_rst    (sys_rst),
        .sys_rst_n  (sys_rst_n)
    );

    always #5 clk_sys = ~clk_sys;

    // cyc = number of rising edges seen; outputs observed at the following falling edge.
    int   cyc = 0;
    logic rst_q = 1'b0;
    always @(posedge clk_sys) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    typedef struct {
        int start;
        int stop;
        int ecnt;
    } win_t;

    win_t exp_pulse[NCH][$];
    win_t exp_rst[$];
    logic done = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk_sys);
    endtask

    // Value applied here is sampled by the DUT at rising edge c.
    task automatic drive_trig(input int c, input int ch, input logic v);
        wait_to(c - 1);
        trig_in[ch] = v;
    endtask

    task automatic drive_ext(input int c, input logic v);
        wait_to(c - 1);
        ext_rst_in = v;
    endtask

    task automatic drive_reset(input int c, input logic v);
        wait_to(c - 1);
        reset = v;
    endtask

    task automatic push_pulse(input int ch, input int s, input int e, input int n);
        win_t w;
        w.start = s;
        w.stop  = e;
        w.ecnt  = n;
        exp_pulse[ch].push_back(w);
    endtask

    task automatic push_rst(input int s, input int e);
        win_t w;
        w.start = s;
        w.stop  = e;
        w.ecnt  = 0;
        exp_rst.push_back(w);
    endtask

    initial begin
        reset      = 1'b1;
        trig_in    = 4'b0100;
        ext_rst_in = 1'b0;

        // Power-on reset sampled through edge 19; stretch of 8 follows release.
        push_rst(1, 27);
        drive_reset(20, 1'b0);

        // ch2 high through reset gives nothing; a fresh rise at 30 does.
        drive_trig(25, 2, 1'b0);
        push_pulse(2, 33, 37, 1);
        drive_trig(30, 2, 1'b1);

        // Single ch0 edge.
        push_pulse(0, 43, 47, 1);
        drive_trig(40, 0, 1'b1);
        drive_trig(45, 0, 1'b0);

        // Second edge: ignored on ch0, retriggers ch1.
        push_pulse(0, 63, 67, 2);
        push_pulse(1, 63, 69, 2);
        drive_trig(60, 0, 1'b1);
        drive_trig(60, 1, 1'b1);
        drive_trig(61, 0, 1'b0);
        drive_trig(61, 1, 1'b0);
        drive_trig(62, 0, 1'b1);
        drive_trig(62, 1, 1'b1);
        drive_trig(64, 0, 1'b0);
        drive_trig(64, 1, 1'b0);

        // External reset request sampled 80..89.
        push_rst(82, 99);
        drive_ext(80, 1'b1);
        drive_ext(90, 1'b0);

        // Short ext request, then a ch3 pulse during COUNT restarts the stretch.
        push_rst(112, 124);
        push_pulse(3, 115, 119, 1);
        drive_ext(110, 1'b1);
        drive_ext(112, 1'b0);
        drive_trig(112, 3, 1'b1);
        drive_trig(114, 3, 1'b0);

        // 254 more accepted edges on ch0 take edge_cnt[0] from 2 through 255 to 0.
        for (int j = 0; j < 254; j++) begin
            push_pulse(0, 140 + 8*j + 3, 140 + 8*j + 7, (3 + j) % 256);
            drive_trig(140 + 8*j, 0, 1'b1);
            drive_trig(140 + 8*j + 1, 0, 1'b0);
        end

        // Reset mid-pulse on ch1: pulse cut after two cycles, counters cleared.
        push_pulse(1, 2203, 2204, 0);
        push_rst(2205, 2217);
        drive_trig(2200, 1, 1'b1);
        drive_reset(2205, 1'b1);
        drive_reset(2210, 1'b0);

        wait_to(2240);
        done = 1'b1;
    end

    logic [NCH-1:0] pprev = '0;
    int             pstart[NCH];
    logic           rprev = 1'b0;
    int             rstart = 0;
    win_t           mw;

    always @(negedge clk_sys) begin
        if (cyc >= 1) begin
            vectors++;
            if (sys_rst_n !== ~sys_rst) begin
                miscompares++;
                $display("FAIL rst_n_complement cyc=%0d sys_rst=%b sys_rst_n=%b", cyc, sys_rst, sys_rst_n);
            end

            if (rst_q) begin
                vectors++;
                if (pulse_out !== '0 || edge_cnt !== '0 || sys_rst !== 1'b1 || sys_rst_n !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset_state cyc=%0d got pulse=%b edge_cnt=%h sys_rst=%b sys_rst_n=%b want 0 0 1 0",
                             cyc, pulse_out, edge_cnt, sys_rst, sys_rst_n);
                end
            end

            for (int i = 0; i < NCH; i++) begin
                if (pulse_out[i] === 1'b1 && !pprev[i]) pstart[i] = cyc;
                if (pulse_out[i] !== 1'b1 && pprev[i]) begin
                    vectors++;
                    if (exp_pulse[i].size() == 0) begin
                        miscompares++;
                        $display("FAIL pulse_unexpected ch%0d got %0d..%0d want none", i, pstart[i], cyc - 1);
                    end else begin
                        mw = exp_pulse[i].pop_front();
                        if (mw.start != pstart[i] || mw.stop != cyc - 1 || mw.ecnt != int'(edge_cnt[8*i +: 8])) begin
                            miscompares++;
                            $display("FAIL pulse_window ch%0d got %0d..%0d cnt=%0d want %0d..%0d cnt=%0d",
                                     i, pstart[i], cyc - 1, edge_cnt[8*i +: 8], mw.start, mw.stop, mw.ecnt);
                        end
                    end
                end
                pprev[i] = (pulse_out[i] === 1'b1);
            end

            if (sys_rst === 1'b1 && !rprev) rstart = cyc;
            if (sys_rst !== 1'b1 && rprev) begin
                vectors++;
                if (exp_rst.size() == 0) begin
                    miscompares++;
                    $display("FAIL rst_unexpected got %0d..%0d want none", rstart, cyc - 1);
                end else begin
                    mw = exp_rst.pop_front();
                    if (mw.start != rstart || mw.stop != cyc - 1) begin
                        miscompares++;
                        $display("FAIL rst_window got %0d..%0d want %0d..%0d", rstart, cyc - 1, mw.start, mw.stop);
                    end
                end
            end
            rprev = (sys_rst === 1'b1);

            if (done) begin
                for (int i = 0; i < NCH; i++) begin
                    vectors++;
                    if (exp_pulse[i].size() != 0) begin
                        miscompares++;
                        $display("FAIL pulse_missing ch%0d got %0d outstanding want 0", i, exp_pulse[i].size());
                    end
                end
                vectors++;
                if (exp_rst.size() != 0) begin
                    miscompares++;
                    $display("FAIL rst_missing got %0d outstanding want 0", exp_rst.size());
                end
                vectors++;
                if (pulse_out !== '0 || sys_rst !== 1'b0) begin
                    miscompares++;
                    $display("FAIL idle_end got pulse=%b sys_rst=%b want 0 0", pulse_out, sys_rst);
                end
                $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
                $finish;
            end
        end
    end

endmodule
